// File: rtl/add_acc_pkg.sv
// rtl/add_acc_pkg.sv - shared types for the add/accumulate pipeline
package add_acc_pkg;

    typedef enum logic [1:0] {
        MODE_ADD  = 2'd0,
        MODE_SUB  = 2'd1,
        MODE_ACC  = 2'd2,
        MODE_PASS = 2'd3
    } mode_e;

endpackage

// File: rtl/add_acc_pipe_if.sv
// rtl/add_acc_pipe_if.sv - handshake and data bundle between driver and add_acc_pipe
interface add_acc_pipe_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mode;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             carry;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] txn_cnt;

    // Driver side: produces operands, consumes results.
    modport master (
        output in_valid, a, b, mode, acc_clr, out_ready,
        input  in_ready, out_valid, y, carry, acc, txn_cnt
    );

    // Block side.
    modport slave (
        input  in_valid, a, b, mode, acc_clr, out_ready,
        output in_ready, out_valid, y, carry, acc, txn_cnt
    );
endinterface

// File: rtl/add_acc_core.sv
// rtl/add_acc_core.sv - combinational ADD/SUB/ACC/PASS datapath (saturation under ADD_ACC_SATURATE_EN)
module add_acc_core
    import add_acc_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  mode_e            mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] acc,
    input  logic             clr,
    output logic [WIDTH-1:0] y_next,
    output logic             carry_next
);

    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum;

    // One WIDTH+1 bit sum serves every mode; the top bit is carry or borrow.
    // A clear in the same cycle as an ACC beat zeroes the accumulator first.
    always_comb begin
        base       = clr ? '0 : acc;
        sum        = '0;
        y_next     = '0;
        carry_next = 1'b0;
        case (mode)
            MODE_ADD: begin
                sum        = {1'b0, a} + {1'b0, b};
                y_next     = sum[WIDTH-1:0];
                carry_next = sum[WIDTH];
`ifdef ADD_ACC_SATURATE_EN
                if (sum[WIDTH]) y_next = '1;
`endif
            end
            MODE_SUB: begin
                sum        = {1'b0, a} - {1'b0, b};
                y_next     = sum[WIDTH-1:0];
                carry_next = sum[WIDTH];
`ifdef ADD_ACC_SATURATE_EN
                if (sum[WIDTH]) y_next = '0;
`endif
            end
            MODE_ACC: begin
                sum        = {1'b0, base} + {1'b0, a};
                y_next     = sum[WIDTH-1:0];
                carry_next = sum[WIDTH];
`ifdef ADD_ACC_SATURATE_EN
                if (sum[WIDTH]) y_next = '1;
`endif
            end
            default: begin
                y_next     = a;
                carry_next = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/add_acc_pipe.sv
// rtl/add_acc_pipe.sv - registered add/accumulate block with valid/ready handshake (option: ADD_ACC_SATURATE_EN)
module add_acc_pipe
    import add_acc_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    add_acc_pipe_if.slave bus
);

    logic [WIDTH-1:0] y_q;
    logic             carry_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] txn_cnt_q;
    logic [WIDTH-1:0] y_next;
    logic             carry_next;
    logic             accept;
    mode_e            mode;

    assign mode   = mode_e'(bus.mode);

    // One-deep output stage: a free slot or a consumed one both admit a new beat.
    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    add_acc_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .mode       (mode),
        .a          (bus.a),
        .b          (bus.b),
        .acc        (acc_q),
        .clr        (bus.acc_clr),
        .y_next     (y_next),
        .carry_next (carry_next)
    );

    // Output register and valid flag; y/carry keep their value once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            y_q         <= y_next;
            carry_q     <= carry_next;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Accumulator: loads on accepted ACC beats, otherwise honours a standalone clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept && (mode == MODE_ACC)) begin
            acc_q <= y_next;
        end else if (bus.acc_clr) begin
            acc_q <= '0;
        end
    end

    // Accepted-beat counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_cnt_q <= '0;
        end else if (accept) begin
            txn_cnt_q <= txn_cnt_q + 1'b1;
        end
    end

    assign bus.y         = y_q;
    assign bus.carry     = carry_q;
    assign bus.out_valid = out_valid_q;
    assign bus.acc       = acc_q;
    assign bus.txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_add_acc_pipe.sv
// tb/tb_add_acc_pipe.sv - directed self-checking bench for add_acc_pipe
module tb_add_acc_pipe;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    add_acc_pipe_if #(.WIDTH(4), .CNT_W(8)) bus ();

    add_acc_pipe #(.WIDTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one beat, let it be accepted at the next edge, sample 1 ns later.
    task automatic beat(input logic [1:0] m, input logic [3:0] av, input logic [3:0] bv, input logic clr);
        bus.mode     = m;
        bus.a        = av;
        bus.b        = bv;
        bus.acc_clr  = clr;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.acc_clr  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.mode     = 2'd0;
        bus.acc_clr  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_y",         32'(bus.y),         0);
        check("rst_carry",     32'(bus.carry),     0);
        check("rst_acc",       32'(bus.acc),       0);
        check("rst_txn",       32'(bus.txn_cnt),   0);
        check("rst_in_ready",  32'(bus.in_ready),  1);

        // ADD 4 + 12 overflows
        beat(2'd0, 4'd4, 4'd12, 1'b0);
        check("add_valid", 32'(bus.out_valid), 1);
`ifdef ADD_ACC_SATURATE_EN
        check("add_y", 32'(bus.y), 15);
`else
        check("add_y", 32'(bus.y), 0);
`endif
        check("add_carry", 32'(bus.carry),   1);
        check("add_txn",   32'(bus.txn_cnt), 1);

        // SUB with borrow, then back-to-back SUB without borrow
        beat(2'd1, 4'd2, 4'd5, 1'b0);
`ifdef ADD_ACC_SATURATE_EN
        check("sub_borrow_y", 32'(bus.y), 0);
`else
        check("sub_borrow_y", 32'(bus.y), 13);
`endif
        check("sub_borrow_c", 32'(bus.carry), 1);
        beat(2'd1, 4'd7, 4'd5, 1'b0);
        check("sub_b2b_valid", 32'(bus.out_valid), 1);
        check("sub_y",         32'(bus.y),         2);
        check("sub_c",         32'(bus.carry),     0);
        check("sub_txn",       32'(bus.txn_cnt),   3);

        // Accumulate 5, 7, 9
        beat(2'd2, 4'd5, 4'd3, 1'b0);
        check("acc1_y",   32'(bus.y),   5);
        check("acc1_acc", 32'(bus.acc), 5);
        check("acc1_c",   32'(bus.carry), 0);
        beat(2'd2, 4'd7, 4'd3, 1'b0);
        check("acc2_y",   32'(bus.y),   12);
        check("acc2_acc", 32'(bus.acc), 12);
        beat(2'd2, 4'd9, 4'd3, 1'b0);
`ifdef ADD_ACC_SATURATE_EN
        check("acc3_y",   32'(bus.y),   15);
        check("acc3_acc", 32'(bus.acc), 15);
`else
        check("acc3_y",   32'(bus.y),   5);
        check("acc3_acc", 32'(bus.acc), 5);
`endif
        check("acc3_c",   32'(bus.carry),   1);
        check("acc3_txn", 32'(bus.txn_cnt), 6);

        // Clear and ACC in the same beat
        beat(2'd2, 4'd3, 4'd0, 1'b1);
        check("clracc_y",   32'(bus.y),     3);
        check("clracc_acc", 32'(bus.acc),   3);
        check("clracc_c",   32'(bus.carry), 0);

        // Standalone clear, no beat: output drains, y holds
        bus.acc_clr = 1'b1;
        idle_cycle();
        bus.acc_clr = 1'b0;
        check("clr_acc",       32'(bus.acc),       0);
        check("drain_valid",   32'(bus.out_valid), 0);
        check("drain_y_hold",  32'(bus.y),         3);
        check("drain_txn",     32'(bus.txn_cnt),   7);

        // PASS ignores b, leaves acc alone
        beat(2'd3, 4'd9, 4'd3, 1'b0);
        check("pass_y",   32'(bus.y),     9);
        check("pass_c",   32'(bus.carry), 0);
        check("pass_acc", 32'(bus.acc),   0);
        check("pass_txn", 32'(bus.txn_cnt), 8);

        // Backpressure: result y=9 held while inputs churn
        bus.out_ready = 1'b0;
        bus.mode      = 2'd0;
        bus.b         = 4'd1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.a = 4'(i + 1);
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 0);
            idle_cycle();
            check("bp_y",     32'(bus.y),         9);
            check("bp_valid", 32'(bus.out_valid), 1);
            check("bp_txn",   32'(bus.txn_cnt),   8);
        end
        bus.a         = 4'd6;
        bus.out_ready = 1'b1;
        #1;
        check("rel_in_ready", 32'(bus.in_ready), 1);
        idle_cycle();
        bus.in_valid = 1'b0;
        check("rel_y",   32'(bus.y),       7);
        check("rel_txn", 32'(bus.txn_cnt), 9);

        // Reset while a result is pending and acc=12
        beat(2'd2, 4'd5, 4'd0, 1'b0);
        beat(2'd2, 4'd7, 4'd0, 1'b0);
        bus.out_ready = 1'b0;
        idle_cycle();
        check("pre_rst_valid", 32'(bus.out_valid), 1);
        check("pre_rst_acc",   32'(bus.acc),       12);
        rst = 1'b1;
        idle_cycle();
        rst = 1'b0;
        check("rst2_valid",    32'(bus.out_valid), 0);
        check("rst2_acc",      32'(bus.acc),       0);
        check("rst2_txn",      32'(bus.txn_cnt),   0);
        check("rst2_in_ready", 32'(bus.in_ready),  1);
        check("rst2_y",        32'(bus.y),         0);

        // Counter wrap after 256 accepts
        bus.out_ready = 1'b1;
        for (int i = 0; i < 255; i++) beat(2'd3, 4'(i), 4'd0, 1'b0);
        check("txn_255", 32'(bus.txn_cnt), 255);
        beat(2'd3, 4'd1, 4'd0, 1'b0);
        check("txn_wrap", 32'(bus.txn_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
